// File: rtl/noc_credit_sink.sv
// -----------------------------------------------------------------------------
// noc_credit_sink
//
// Credit-based flit receiver that terminates one router-to-router port of a
// NoC router. Incoming flits are buffered in a FLIT_BUFFER_DEPTH entry FIFO
// and exposed on a valid/ready stream. Every flit drained from the FIFO
// returns one credit upstream. Flit and packet statistics are kept, along
// with sticky protocol-error flags.
//
// Ports:
//   clk             - single clock
//   rst             - synchronous, active-high reset
//   data_in         - incoming flit payload
//   dest_in         - incoming flit destination
//   is_tail_in      - incoming flit is the last of its packet
//   send_in         - incoming flit valid (one cycle per flit)
//   credit_out      - one-cycle pulse returning one credit upstream
//   out_valid       - FIFO head valid
//   out_ready       - consumer accepts the head
//   out_data        - head payload
//   out_dest        - head destination
//   out_last        - head is the tail of its packet
//   flit_count      - number of flits accepted (wraps)
//   pkt_count       - number of tail flits accepted (wraps)
//   err_overflow    - sticky: a flit arrived while the FIFO had no space
//   err_dest_change - sticky: destination changed inside a packet
// -----------------------------------------------------------------------------
module noc_credit_sink #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLIT_WIDTH-1:0]  out_data,
  output logic [DEST_WIDTH-1:0]  out_dest,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] flit_count,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic                   err_overflow,
  output logic                   err_dest_change
);

  localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int OCC_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FLIT_BUFFER_DEPTH);

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } state_t;

  logic [FLIT_WIDTH-1:0] mem_data [FLIT_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] mem_dest [FLIT_BUFFER_DEPTH];
  logic                  mem_last [FLIT_BUFFER_DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occupancy;
  state_t                state;
  logic [DEST_WIDTH-1:0] pkt_dest;

  logic push;
  logic pop;

  // The head is valid purely from registered occupancy, so out_valid never
  // depends on out_ready. A pop frees a slot in the same cycle, which lets a
  // flit arriving on a full FIFO still be accepted.
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign push      = send_in && ((occupancy != FULL_OCC) || pop);

  assign out_data = mem_data[rd_ptr];
  assign out_dest = mem_dest[rd_ptr];
  assign out_last = mem_last[rd_ptr];

  // Flit storage is deliberately left out of reset; only the pointers and
  // occupancy decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= data_in;
      mem_dest[wr_ptr] <= dest_in;
      mem_last[wr_ptr] <= is_tail_in;
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap explicitly so that
  // non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // At most one pop happens per cycle, so the credit pulse is simply the
  // pop strobe delayed by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= pop;
    end
  end

  // Input packet tracker, statistics and error flags. Everything here moves
  // only on an accepted flit, except the overflow flag which records a flit
  // that had to be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HEAD;
      pkt_dest        <= '0;
      flit_count      <= '0;
      pkt_count       <= '0;
      err_overflow    <= 1'b0;
      err_dest_change <= 1'b0;
    end else begin
      if (send_in && !push) begin
        err_overflow <= 1'b1;
      end
      if (push) begin
        flit_count <= flit_count + 1'b1;
        if (is_tail_in) begin
          pkt_count <= pkt_count + 1'b1;
        end
        case (state)
          HEAD: begin
            pkt_dest <= dest_in;
            state    <= is_tail_in ? HEAD : BODY;
          end
          BODY: begin
            if (dest_in != pkt_dest) begin
              err_dest_change <= 1'b1;
            end
            if (is_tail_in) begin
              state <= HEAD;
            end
          end
          default: state <= HEAD;
        endcase
      end
    end
  end

endmodule

// File: doc/noc_credit_sink.md
# noc_credit_sink

Credit-based flit receiver that terminates one router-to-router output port (`data_out`/`dest_out`/`is_tail_out`/`send_out`/`credit_in`) of a NoC router. It buffers incoming flits in a FLIT_BUFFER_DEPTH FIFO and returns one credit per flit drained. It presents flits on a valid/ready stream and keeps packet statistics and sticky protocol-error flags. It is used as the endpoint on unconnected mesh-edge ports and as the measurement sink in the router parameter sweeps.

## Interface
Parameters:
- `FLIT_WIDTH`, 32: flit payload width.
- `DEST_WIDTH`, 6: destination field width ({tid, tdest}).
- `FLIT_BUFFER_DEPTH`, 8: FIFO depth; ≥2, any integer (not limited to powers of two). It equals the credit count the upstream router starts with.
- `COUNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, FLIT_WIDTH: flit payload.
- `dest_in`, input, DEST_WIDTH: flit destination.
- `is_tail_in`, input, 1: flit is the last of its packet.
- `send_in`, input, 1: flit valid, one cycle per flit.
- `credit_out`, output, 1: one-cycle pulse that returns one credit upstream.
- `out_valid`, output, 1: FIFO head valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_data`, output, FLIT_WIDTH: head payload.
- `out_dest`, output, DEST_WIDTH: head destination.
- `out_last`, output, 1: head is_tail.
- `flit_count`, output, COUNT_WIDTH: flits accepted into the FIFO.
- `pkt_count`, output, COUNT_WIDTH: tail flits accepted.
- `err_overflow`, output, 1: sticky; a flit arrived with no space.
- `err_dest_change`, output, 1: sticky; dest changed within a packet.

## Operation
- **push** = `send_in` && (occupancy < FLIT_BUFFER_DEPTH || pop). A push writes {data, dest, is_tail} at the write pointer.
- **pop** = `out_valid` && `out_ready`. It advances the read pointer.
- Both pointers wrap from FLIT_BUFFER_DEPTH-1 to 0. Occupancy updates by +push −pop; a simultaneous push and pop leaves it unchanged.
- **Overflow:** `send_in` with occupancy == FLIT_BUFFER_DEPTH and no pop drops the flit. `err_overflow` sets and stays set until reset. The counters and the input FSM do not change.
- **Credit return:** every pop produces exactly one `credit_out` pulse. Pops never coincide, so the pulse is a registered copy of pop.
- **Input packet FSM**, which advances on push only:
  - HEAD: latch `dest_in` into `pkt_dest`. If `is_tail_in` is set, stay in HEAD; otherwise go to BODY.
  - BODY: if `dest_in` != `pkt_dest`, set `err_dest_change` (sticky); the flit is still stored. If `is_tail_in` is set, go to HEAD.
  - A single-flit packet (head that is also tail) counts as one packet.
- **Counters:** `flit_count` increments on each push and `pkt_count` on each push with `is_tail_in`. Both wrap modulo 2^COUNT_WIDTH.
- **Output ports:** `out_data`, `out_dest` and `out_last` reflect the FIFO head whenever `out_valid` = 1. They are don't-care otherwise.

## Timing
- **Reset values:** occupancy 0, both pointers 0, FSM in HEAD, `credit_out` 0, `out_valid` 0, `flit_count` 0, `pkt_count` 0, both error flags 0. FIFO storage is not reset.
- Reset asserted mid-packet discards all buffered flits and issues no credits for them. Upstream must be reset in the same cycle.
- **Latency:** a flit pushed in cycle t appears at the head with `out_valid` = 1 in cycle t+1 if the FIFO was empty.
- **Credit timing:** a pop in cycle t gives `credit_out` = 1 in cycle t+1.
- With `out_ready` held at 1, sustained throughput is one flit per cycle. Each flit then spends one cycle in the FIFO and its credit returns two cycles after its send.
- **Stream handshake:** `out_valid` does not depend combinationally on `out_ready`. The head stays stable while `out_valid` && !`out_ready`.
- **Full FIFO:** a push in the same cycle as a pop is accepted; `out_ready` → push enable is a combinational path.
- **Statistics timing:** `flit_count`, `pkt_count` and the error flags update in cycle t+1 for an event in cycle t.

## Test plan
1. **Single-flit packet.** After reset, send one flit: data 0xA5A5_0001, dest 0x05, tail 1, with `out_ready` = 1.
   - `out_valid` pulses in cycle t+1 with that data, dest and `out_last` = 1.
   - `credit_out` pulses in cycle t+2.
   - Final state: `flit_count` = 1, `pkt_count` = 1, no errors.
2. **Fill and hold.** With `out_ready` = 0, send 8 flits of one packet (dest 0x12, tail on the 8th).
   - Occupancy reaches 8 and no `credit_out` is issued.
   - Then raise `out_ready` for 8 cycles: the flits drain in order, with 8 credit pulses each one cycle after its pop.
   - Final state: `pkt_count` = 1.
3. **Overflow.** With the FIFO full and `out_ready` = 0, send a 9th flit.
   - The flit is dropped, `err_overflow` = 1 and `flit_count` stays 8.
   - A repeat on the full FIFO with `out_ready` = 1 in the same cycle is accepted, and occupancy stays 8.
4. **Dest change inside a packet.** Send a 3-flit packet with dests 0x03, 0x03, 0x07.
   - `err_dest_change` = 1 after the 3rd flit.
   - All 3 flits are delivered and `pkt_count` = 1.
   - A following packet with dest 0x07 raises no new error.
5. **Pointer wrap under streaming.** Send 1000 back-to-back flits with `out_ready` randomly toggled, and upstream obeying an 8-credit model.
   - Output order and content are preserved.
   - Total credit pulses equal total pops, and `err_overflow` stays 0.
6. **Reset mid-packet.** After 2 flits of a 4-flit packet are buffered, assert `rst` for 1 cycle.
   - `out_valid` = 0, counters and flags are 0, and the FSM is in HEAD.
   - A new packet after reset is received normally.
